// File: rtl/lse_pkg.sv
// Shared types and constants for the log-domain add/subtract units.
package lse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_LOOKUP,
        S_CORRECT,
        S_HOLD
    } lse_sub_state_t;

    typedef enum logic [2:0] {
        BOTH_NEG_INF,
        B_NEG_INF,
        A_NEG_INF_ERR,
        A_LT_B_ERR,
        EQUAL,
        NORMAL
    } lse_sub_case_t;

    // Most negative code of a width-bit log value stands for log(0).
    function automatic logic [63:0] neg_inf(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] min_fin(input int unsigned width);
        return neg_inf(width) + 64'd1;
    endfunction

endpackage

// File: rtl/lse_sub_classify.sv
// Combinational operand classifier: special-value detection and LUT index.
module lse_sub_classify
    import lse_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int LUT_SIZE   = 1024,
    parameter int STEP_SHIFT = 4,
    parameter int IDX_W      = $clog2(LUT_SIZE)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output lse_sub_case_t    o_case,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_far
);

    localparam logic [WIDTH-1:0] NEG_INF = WIDTH'(neg_inf(WIDTH));

    logic             w_a_inf;
    logic             w_b_inf;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shifted;

    always_comb begin
        w_a_inf   = (i_a == NEG_INF);
        w_b_inf   = (i_b == NEG_INF);
        // One extra bit keeps a - b exact across the full signed range.
        w_diff    = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
        w_shifted = w_diff >> STEP_SHIFT;
        o_far     = (w_shifted >= (WIDTH+1)'(LUT_SIZE));
        o_idx     = w_shifted[IDX_W-1:0];

        if (w_a_inf && w_b_inf) begin
            o_case = BOTH_NEG_INF;
        end else if (w_b_inf) begin
            o_case = B_NEG_INF;
        end else if (w_a_inf) begin
            o_case = A_NEG_INF_ERR;
        end else if ($signed(i_a) < $signed(i_b)) begin
            o_case = A_LT_B_ERR;
        end else if (i_a == i_b) begin
            o_case = EQUAL;
        end else begin
            o_case = NORMAL;
        end
    end

endmodule

// File: rtl/lse_sub.sv
// Log-domain subtractor: result = log(exp(a) - exp(b)) with a caller-supplied
// correction table, fixed five-state handshake pipeline.
module lse_sub
    import lse_pkg::*;
#(
    parameter int WIDTH         = 24,
    parameter int LUT_SIZE      = 1024,
    parameter int LUT_PRECISION = 10,
    parameter int STEP_SHIFT    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  operand_a,
    input  logic [WIDTH-1:0]                  operand_b,
    input  logic [LUT_PRECISION*LUT_SIZE-1:0] lut_table,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  result,
    output logic                              err
);

    localparam int               IDX_W     = $clog2(LUT_SIZE);
    localparam logic [WIDTH-1:0] NEG_INF   = WIDTH'(neg_inf(WIDTH));
    localparam logic [WIDTH-1:0] MIN_FIN   = WIDTH'(min_fin(WIDTH));
    localparam logic [WIDTH:0]   MIN_FIN_X = {1'b1, MIN_FIN};

    lse_sub_state_t             r_state;
    lse_sub_state_t             w_next_state;
    logic [WIDTH-1:0]           r_a;
    logic [WIDTH-1:0]           r_b;
    lse_sub_case_t              r_case;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_far;
    logic [LUT_PRECISION-1:0]   r_corr;
    logic [WIDTH-1:0]           r_result;
    logic                       r_err;
    logic                       r_out_valid;

    lse_sub_case_t              w_case;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_far;
    logic [LUT_PRECISION-1:0]   w_lut [LUT_SIZE];
    logic [WIDTH:0]             w_r;
    logic                       w_sat;

    lse_sub_classify #(
        .WIDTH      (WIDTH),
        .LUT_SIZE   (LUT_SIZE),
        .STEP_SHIFT (STEP_SHIFT),
        .IDX_W      (IDX_W)
    ) u_classify (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_case (w_case),
        .o_idx  (w_idx),
        .o_far  (w_far)
    );

    always_comb begin
        for (int i = 0; i < LUT_SIZE; i++) begin
            w_lut[i] = lut_table[i*LUT_PRECISION +: LUT_PRECISION];
        end
    end

    // Sign-extended a minus zero-extended correction; saturate below MIN_FIN.
    always_comb begin
        w_r   = {r_a[WIDTH-1], r_a} - (WIDTH+1)'(r_corr);
        w_sat = ($signed(w_r) < $signed(MIN_FIN_X));
    end

    // NOTE: state holds only flops; next-state logic lives in always_comb with
    // a default first so no path can infer a latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_CLASSIFY;
            end
            S_CLASSIFY: w_next_state = S_LOOKUP;
            S_LOOKUP:   w_next_state = S_CORRECT;
            S_CORRECT:  w_next_state = S_HOLD;
            S_HOLD:     if (out_ready) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_case      <= BOTH_NEG_INF;
            r_idx       <= '0;
            r_far       <= 1'b0;
            r_corr      <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= operand_a;
                        r_b <= operand_b;
                    end
                end
                S_CLASSIFY: begin
                    r_case <= w_case;
                    r_idx  <= w_idx;
                    r_far  <= w_far;
                end
                S_LOOKUP: begin
                    r_corr <= (r_case == NORMAL && !r_far) ? w_lut[r_idx] : '0;
                end
                S_CORRECT: begin
                    r_out_valid <= 1'b1;
                    r_err       <= (r_case == A_NEG_INF_ERR) || (r_case == A_LT_B_ERR);
                    case (r_case)
                        B_NEG_INF: r_result <= r_a;
                        NORMAL:    r_result <= w_sat ? MIN_FIN : w_r[WIDTH-1:0];
                        default:   r_result <= NEG_INF;
                    endcase
                end
                S_HOLD: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err       = r_err;

endmodule
